// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit
// multiplexed seven-segment ALU result display.
package seg_pkg;

  localparam int NDIGITS      = 4;
  localparam int PRESCALE_DEF = 50000;

  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_MINUS = 8'hBF;
  localparam logic [7:0] GLYPH_C     = 8'hC6;
  localparam logic [7:0] GLYPH_O     = 8'hA3;

  localparam logic [3:0] AN_OFF = 4'hF;

  typedef struct packed {
    logic [3:0] res;
    logic       car;
    logic       of;
    logic       sgn;
  } word_t;

  localparam word_t WORD_ZERO = '0;

endpackage

// File: rtl/seg_scan_if.sv
// Valid/ready bundle carrying one ALU
// result/flag word into the display block.
interface seg_scan_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_res;
  logic       in_car;
  logic       in_of;
  logic       in_signed;

  modport master (
    output in_valid,
    output in_res,
    output in_car,
    output in_of,
    output in_signed,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_res,
    input  in_car,
    input  in_of,
    input  in_signed,
    output in_ready
  );
endinterface

// File: rtl/seg_dec.sv
// Combinational hex digit to active-low
// seven-segment glyph decoder, dp off.
module seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] val,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    unique case (val)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      4'hF: glyph = 8'h8E;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 4-digit display of an ALU word:
// magnitude, sign, carry and overflow digits.
module seg_scan
  import seg_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NDIGITS);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic          pend_valid;
  logic          pv_nxt;
  word_t         pend;
  word_t         disp;
  word_t         disp_nxt;
  logic          tick;
  logic          bnd;
  logic          accept;
  logic          load;
  logic          neg;
  logic [3:0]    mag;
  logic [7:0]    hex;
  logic [7:0]    glyph;
  logic [3:0]    an_nxt;

  assign tick    = cnt == CW'(PRESCALE - 1);
  assign bnd     = tick && (idx == IW'(NDIGITS - 1));
  assign accept  = bus.in_valid && bus.in_ready;
  assign load    = bnd && pend_valid;
  assign idx_nxt = idx + 1'b1;

  always_comb begin
    pv_nxt = pend_valid;
    if (load)
      pv_nxt = 1'b0;
    else if (accept)
      pv_nxt = 1'b1;
  end

  // digits are built from the value that is visible after this edge
  assign disp_nxt = load ? pend : disp;
  assign neg = disp_nxt.sgn && disp_nxt.res[3];
  assign mag = neg ? (~disp_nxt.res + 4'd1)
                   : disp_nxt.res;

  seg_dec u_dec (
    .val   (mag),
    .glyph (hex)
  );

  always_comb begin
    glyph  = GLYPH_BLANK;
    an_nxt = ~(4'b0001 << idx_nxt);
    unique case (idx_nxt)
      2'd0: glyph = hex;
      2'd1: glyph = neg ? GLYPH_MINUS
                        : GLYPH_BLANK;
      2'd2: glyph = disp_nxt.car ? GLYPH_C
                                 : GLYPH_BLANK;
      2'd3: glyph = disp_nxt.of ? GLYPH_O
                                : GLYPH_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= IW'(NDIGITS - 1);
      pend_valid   <= 1'b0;
      pend         <= WORD_ZERO;
      disp         <= WORD_ZERO;
      bus.in_ready <= 1'b1;
      seg          <= GLYPH_BLANK;
      an           <= AN_OFF;
      frame_done   <= 1'b0;
    end else begin
      cnt          <= tick ? '0 : cnt + 1'b1;
      pend_valid   <= pv_nxt;
      bus.in_ready <= !pv_nxt;
      frame_done   <= bnd;
      if (accept) begin
        pend.res <= bus.in_res;
        pend.car <= bus.in_car;
        pend.of  <= bus.in_of;
        pend.sgn <= bus.in_signed;
      end
      if (load)
        disp <= pend;
      if (tick) begin
        idx <= idx_nxt;
        seg <= glyph;
        an  <= an_nxt;
      end
    end
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The module SHALL have parameter PRESCALE, default 50000, giving the clock cycles per digit slot (minimum 2).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  the ALU result/flag word is presented.
REQ-005 in_ready  output  1  the block can accept a word.
REQ-006 in_res  input  4  the ALU result.
REQ-007 in_car  input  1  the ALU carry flag.
REQ-008 in_of  input  1  the ALU overflow flag.
REQ-009 in_signed  input  1  interpret in_res as two's complement.
REQ-010 seg  output  8  active-low segments: bit0=a through bit6=g, bit7=dp.
REQ-011 an  output  4  active-low one-hot digit enable; an[0] is the rightmost digit.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 A word SHALL be accepted on a rising edge where in_valid && in_ready; it is stored in a pending register, and pend_valid is set.
REQ-014 in_ready SHALL be registered and SHALL equal !pend_valid.
- Words offered while in_ready=0 are ignored.
REQ-015 The prescaler SHALL count 0..PRESCALE-1 and wrap.
- tick is asserted when count==PRESCALE-1.
REQ-016 On each tick, the digit index SHALL advance cyclically 0→1→2→3→0.
- Reset value of the digit index is 3.
REQ-017 A frame boundary is a tick where the index wraps from 3 to 0.
- If pend_valid=1 at the boundary, the display register SHALL load the pending word on that edge and pend_valid SHALL clear.
- frame_done SHALL be 1 for exactly that one cycle.
REQ-018 If a word is accepted on the same edge as a frame boundary with pend_valid=0, it SHALL go to pending and be displayed at the following boundary, not this one.
REQ-019 seg and an SHALL be registered and updated only on tick edges.
- They SHALL present the new digit, computed from the post-load display value, on the same edge.
REQ-020 Digit contents:
- d0: hex glyph of the magnitude of res; when in_signed=1 and res[3]=1, the magnitude is the two's-complement value (4'b1000 displays 8).
- d1: '-' (BF) when the value is signed-negative, otherwise blank.
- d2: 'C' (C6) if car=1, otherwise blank.
- d3: 'o' (A3) if of=1, otherwise blank.
REQ-021 Blank SHALL be FF.
- Hex glyphs: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- dp is always off.
REQ-022 Between reset release and the first tick, an SHALL be F (display dark).

Reset
REQ-023 While rst_n=0, the outputs SHALL take these values immediately, regardless of clk: seg=FF, an=F, frame_done=0, in_ready=1.
REQ-024 Reset SHALL also clear the prescaler to 0, set the digit index to 3, clear pend_valid, and set the display register to res=0, car=0, of=0, signed=0.
REQ-025 Reset asserted mid-frame or mid-handshake SHALL discard the pending word with no partial update after release.

Structure
REQ-026 Package seg_pkg SHALL hold:
- the glyph constants, including blank, minus, C and o;
- the digit-count constant (4);
- the PRESCALE default.
REQ-027 Sub-module seg_dec SHALL be a combinational 4-bit-to-8-bit hex glyph decoder, instantiated once for d0.

Verification (PRESCALE=4)
REQ-028 Reset: hold rst_n=0 → seg=FF, an=F, in_ready=1. Release → the first tick occurs 4 cycles later, with an=E, seg=C0 and frame_done pulsed.
REQ-029 Load res=5, car=1, of=0, signed=0 → in_ready=0 next cycle. At the next boundary: d0=92, d1=FF, d2=C6, d3=FF, and in_ready returns to 1.
REQ-030 Load res=4'b1000, of=1, signed=1 → d0=80, d1=BF, d2=FF, d3=A3.
REQ-031 Offer res=3 while in_ready=0 after an accepted res=7 → the display shows 7 (F8), and 3 never appears.
REQ-032 Accept res=2 on the boundary edge → that frame shows the old value, and the next frame shows A4.
REQ-033 Drop rst_n mid-scan with a word pending → seg=FF and an=F immediately. After release, the first frame shows C0.
